// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle from the UART receiver to the word consumer.
// Latency: none; plain wires between producer and consumer.
// Backpressure: none; the consumer samples on the one-cycle dout_vld strobe.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 dout_vld;
    logic [DATA_BITS-1:0] dout;
    logic                 parity_err;
    logic                 frame_err;
    logic                 brk_det;
    logic                 busy;

    modport master (
        output dout_vld,
        output dout,
        output parity_err,
        output frame_err,
        output brk_det,
        output busy
    );

    modport slave (
        input dout_vld,
        input dout,
        input parity_err,
        input frame_err,
        input brk_det,
        input busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority vote, parity/framing/break flags, busy.
// Latency: 3 + (N-1)*CLKS_PER_BIT + DEC + 1 cycles from line fall to dout_vld (N bit slots).
// Backpressure: none; dout_vld is a one-cycle strobe and results hold until the next frame.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT  = 400,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int SAMPLE_SPREAD = 20
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          bit_in,
    uart_rx_cfg_if.master rx
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] SMP_LO   = CW'(MID - SAMPLE_SPREAD);
    localparam logic [CW-1:0] SMP_MID  = CW'(MID);
    localparam logic [CW-1:0] SMP_HI   = CW'(MID + SAMPLE_SPREAD);
    localparam logic [CW-1:0] DEC      = CW'(MID + SAMPLE_SPREAD + 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic          HAS_PAR  = (PARITY != 0);
    localparam logic          ODD_PAR  = (PARITY == 1);
    localparam logic          TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [2:0]           sync;
    logic                 prev;
    logic [CW-1:0]        clk_cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [1:0]           tally;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_pend;

    logic wrap;
    logic at_dec;
    logic at_smp;
    logic vote;
    logic fall;
    logic last_stop;
    logic ferr_now;
    logic perr_now;
    logic brk_now;

    assign wrap      = (clk_cnt == LAST);
    assign at_dec    = (clk_cnt == DEC);
    assign at_smp    = (clk_cnt == SMP_LO) || (clk_cnt == SMP_MID) || (clk_cnt == SMP_HI);
    // Tally never exceeds 3, so its MSB is exactly "at least two of three high".
    assign vote      = tally[1];
    assign fall      = prev & ~sync[2];
    assign last_stop = (stop_idx == TWO_STOP);
    assign ferr_now  = ferr_pend | ~vote;
    assign perr_now  = HAS_PAR & ((^shreg ^ par_bit) != ODD_PAR);
    assign brk_now   = (shreg == '0) & (~HAS_PAR | ~par_bit) & ferr_now;

    // Metastability chain on the raw line plus one extra stage for edge detection; idles high.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync <= 3'b111;
            prev <= 1'b1;
        end else begin
            sync <= {sync[1:0], bit_in};
            prev <= sync[2];
        end
    end

    // Frame FSM: bit timing, vote tally, data capture and registered result outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            tally         <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            ferr_pend     <= 1'b0;
            rx.dout       <= '0;
            rx.dout_vld   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.brk_det    <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.dout_vld <= 1'b0;

            // Bit-period counter and vote tally run in every active state; exits below override.
            if (state != IDLE) begin
                clk_cnt <= wrap ? '0 : clk_cnt + CNT_ONE;
                if (at_smp) begin
                    tally <= tally + {1'b0, sync[2]};
                end else if (at_dec) begin
                    tally <= '0;
                end
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    // Only a genuine high-to-low transition starts a frame; a stuck-low line does not.
                    if (fall) begin
                        state     <= START;
                        stop_idx  <= 1'b0;
                        ferr_pend <= 1'b0;
                        rx.busy   <= 1'b1;
                    end
                end
                START: begin
                    if (at_dec && vote) begin
                        // Line was back high by mid-bit: treat as a glitch.
                        state   <= IDLE;
                        clk_cnt <= '0;
                        rx.busy <= 1'b0;
                    end else if (wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (at_dec) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (wrap) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= HAS_PAR ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end
                end
                PAR: begin
                    if (at_dec) begin
                        par_bit <= vote;
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (at_dec) begin
                        if (last_stop) begin
                            // Finish at the decide point of the final stop bit to tolerate fast senders.
                            state         <= IDLE;
                            clk_cnt       <= '0;
                            stop_idx      <= 1'b0;
                            ferr_pend     <= 1'b0;
                            rx.busy       <= 1'b0;
                            rx.dout_vld   <= 1'b1;
                            rx.dout       <= shreg;
                            rx.parity_err <= perr_now;
                            rx.frame_err  <= ferr_now;
                            rx.brk_det    <= brk_now;
                        end else begin
                            ferr_pend <= ferr_now;
                        end
                    end else if (wrap) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                    rx.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two instances (8N1 at 400 cycles/bit, 7E2 at 16 cycles/bit).
// Stimulus pushes expected words into per-instance queues; negedge monitors pop and compare.
// Directed cases cover glitch, break, vote, reset; random frames exercise the 7E2 instance.
module tb_uart_rx_cfg;
    localparam int A_CPB = 400;
    localparam int A_DB  = 8;
    localparam int A_PAR = 0;
    localparam int A_SB  = 1;
    localparam int A_SS  = 20;
    localparam int B_CPB = 16;
    localparam int B_DB  = 7;
    localparam int B_PAR = 2;
    localparam int B_SB  = 2;
    localparam int B_SS  = 3;

    typedef struct {
        logic [15:0] d;
        logic        pe;
        logic        fe;
        logic        bk;
        longint      cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic bit_in_a;
    logic bit_in_b;
    int   cyc;
    int   checks;
    int   errors;
    bit   abort;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    uart_rx_cfg_if #(.DATA_BITS(A_DB)) rxa ();
    uart_rx_cfg_if #(.DATA_BITS(B_DB)) rxb ();

    uart_rx_cfg #(
        .CLKS_PER_BIT(A_CPB), .DATA_BITS(A_DB), .PARITY(A_PAR),
        .STOP_BITS(A_SB), .SAMPLE_SPREAD(A_SS)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .bit_in(bit_in_a), .rx(rxa)
    );

    uart_rx_cfg #(
        .CLKS_PER_BIT(B_CPB), .DATA_BITS(B_DB), .PARITY(B_PAR),
        .STOP_BITS(B_SB), .SAMPLE_SPREAD(B_SS)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .bit_in(bit_in_b), .rx(rxb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) bit_in_a = v;
        else            bit_in_b = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; optionally record what a correct receiver must report and when.
    task automatic send_frame(input int which, input logic [15:0] data, input logic pbit,
                              input logic s0, input logic s1, input bit push, input logic tail);
        int   cpb, db, nstop, dec;
        logic haspar, odd, x;
        logic bits[$];
        exp_t e;
        if (which == 0) begin
            cpb = A_CPB; db = A_DB; nstop = A_SB; haspar = (A_PAR != 0); odd = (A_PAR == 1);
            dec = A_CPB / 2 + A_SS + 1;
        end else begin
            cpb = B_CPB; db = B_DB; nstop = B_SB; haspar = (B_PAR != 0); odd = (B_PAR == 1);
            dec = B_CPB / 2 + B_SS + 1;
        end
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(data[i]);
        if (haspar) bits.push_back(pbit);
        bits.push_back(s0);
        if (nstop == 2) bits.push_back(s1);
        if (push) begin
            e.d = '0;
            x   = pbit;
            for (int i = 0; i < db; i++) begin
                e.d[i] = data[i];
                x      = x ^ data[i];
            end
            e.fe  = !s0 || (nstop == 2 && !s1);
            e.pe  = haspar && (x != odd);
            e.bk  = (e.d == 16'd0) && (!haspar || !pbit) && e.fe;
            e.cyc = longint'(cyc) + 1 + 3 + longint'((bits.size() - 1) * cpb) + longint'(dec) + 1;
            if (which == 0) qa.push_back(e);
            else            qb.push_back(e);
        end
        foreach (bits[k]) begin
            drive(which, abort ? 1'b1 : bits[k]);
            tick(cpb);
        end
        drive(which, tail);
    endtask

    // Monitor for the 8N1 instance.
    always @(negedge clk) begin
        if (rxa.dout_vld === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_strobe: got dout=%0h at cycle %0d, expected no strobe", rxa.dout, cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_dout", longint'(rxa.dout), longint'(ea.d));
                chk("a_parity_err", longint'(rxa.parity_err), longint'(ea.pe));
                chk("a_frame_err", longint'(rxa.frame_err), longint'(ea.fe));
                chk("a_brk_det", longint'(rxa.brk_det), longint'(ea.bk));
                chk("a_busy_at_vld", longint'(rxa.busy), 0);
                chk("a_latency_cycle", longint'(cyc), ea.cyc);
            end
        end
    end

    // Monitor for the 7E2 instance.
    always @(negedge clk) begin
        if (rxb.dout_vld === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_strobe: got dout=%0h at cycle %0d, expected no strobe", rxb.dout, cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_dout", longint'(rxb.dout), longint'(eb.d));
                chk("b_parity_err", longint'(rxb.parity_err), longint'(eb.pe));
                chk("b_frame_err", longint'(rxb.frame_err), longint'(eb.fe));
                chk("b_brk_det", longint'(rxb.brk_det), longint'(eb.bk));
                chk("b_busy_at_vld", longint'(rxb.busy), 0);
                chk("b_latency_cycle", longint'(cyc), eb.cyc);
            end
        end
    end

    initial begin
        int t0;
        int first;
        int cnt;
        int gap;
        logic [15:0] d;
        logic pb, s0, s1;

        checks   = 0;
        errors   = 0;
        abort    = 1'b0;
        rst_n    = 1'b0;
        bit_in_a = 1'b1;
        bit_in_b = 1'b1;
        tick(4);

        // Reset state.
        chk("rst_a_dout", longint'(rxa.dout), 0);
        chk("rst_a_vld", longint'(rxa.dout_vld), 0);
        chk("rst_a_busy", longint'(rxa.busy), 0);
        chk("rst_a_flags", longint'({rxa.parity_err, rxa.frame_err, rxa.brk_det}), 0);
        chk("rst_b_dout", longint'(rxb.dout), 0);
        chk("rst_b_busy", longint'(rxb.busy), 0);
        rst_n = 1'b1;
        tick(10);

        // Plain 8N1 frame.
        send_frame(0, 16'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(20);

        // 50-cycle low glitch: false start, busy for DEC+1 cycles, no strobe.
        t0 = cyc;
        bit_in_a = 1'b0;
        first = -1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 49) bit_in_a = 1'b1;
            if (rxa.busy === 1'b1) begin
                if (first < 0) first = cyc;
                cnt++;
            end
        end
        chk("glitch_busy_rise_cycle", longint'(first), longint'(t0 + 4));
        chk("glitch_busy_len", longint'(cnt), longint'(A_CPB / 2 + A_SS + 2));
        tick(1);

        // Break: zero data, zero stop bit, line then held low for three frame times.
        send_frame(0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(3 * 10 * A_CPB);
        chk("break_no_retrigger_busy", longint'(rxa.busy), 0);
        bit_in_a = 1'b1;
        tick(100);

        // Single-cycle low pulse at the middle vote sample of data bit 3 of 0xFF.
        t0 = cyc;
        fork
            send_frame(0, 16'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            begin
                while (cyc != t0 + 4 * A_CPB + A_CPB / 2 + 1) tick(1);
                bit_in_a = 1'b0;
                tick(1);
                bit_in_a = 1'b1;
            end
        join
        tick(20);

        // Reset mid-DATA of 0x3C: outputs clear next cycle, no strobe for that frame.
        chk("a_dout_held", longint'(rxa.dout), 16'hFF);
        fork
            send_frame(0, 16'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            begin
                tick(4 * A_CPB + 100);
                chk("mid_frame_busy", longint'(rxa.busy), 1);
                rst_n = 1'b0;
                abort = 1'b1;
                tick(1);
                rst_n = 1'b1;
                chk("rst_mid_dout", longint'(rxa.dout), 0);
                chk("rst_mid_vld", longint'(rxa.dout_vld), 0);
                chk("rst_mid_busy", longint'(rxa.busy), 0);
                chk("rst_mid_flags", longint'({rxa.parity_err, rxa.frame_err, rxa.brk_det}), 0);
            end
        join
        abort = 1'b0;
        tick(50);
        send_frame(0, 16'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(20);

        // 7E2: correct parity, then flipped parity bit.
        send_frame(1, 16'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(5);
        send_frame(1, 16'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Random 7E2 frames, mostly back-to-back, with occasional parity/stop errors and breaks.
        for (int n = 0; n < 40; n++) begin
            d  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 127));
            pb = (^d[6:0]) ^ ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) pb = 1'b0;
            s0 = ($urandom_range(0, 5) != 0);
            s1 = ($urandom_range(0, 5) != 0);
            send_frame(1, d, pb, s0, s1, 1'b1, 1'b1);
            gap = s1 ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 5));
            if (gap > 0) tick(gap);
        end

        // Drain outstanding expectations with a bound.
        for (int i = 0; i < 5000 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
        chk("a_queue_drained", longint'(qa.size()), 0);
        chk("b_queue_drained", longint'(qb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
